// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared widths, FSM state type and digit helper for the BCD datapath
package bcd_pkg;

  localparam int DIGITS  = 4;
  localparam int BCD_W   = 4;
  localparam int BIN_W   = 14;
  localparam int BCD_MAX = 9;
  localparam int CNT_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
    return digit <= BCD_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_times10_add.sv
// rtl/bcd_times10_add.sv - one Horner step: acc*10 + digit, truncated to BIN_W bits
module bcd_times10_add
  import bcd_pkg::*;
(
  input  logic [BIN_W-1:0] acc,
  input  logic [BCD_W-1:0] digit,
  output logic [BIN_W-1:0] result
);

  logic [BIN_W-1:0] acc_x8;
  logic [BIN_W-1:0] acc_x2;
  logic [BIN_W-1:0] digit_ext;

  // Shift-and-add keeps this a pair of adders rather than a multiplier.
  assign acc_x8    = acc << 3;
  assign acc_x2    = acc << 1;
  assign digit_ext = {{(BIN_W-BCD_W){1'b0}}, digit};
  assign result    = acc_x8 + acc_x2 + digit_ext;

endmodule

// File: rtl/bcd2bin4digit.sv
// rtl/bcd2bin4digit.sv - sequential 4-digit BCD to binary converter, one digit per clock
module bcd2bin4digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [BCD_W-1:0] A,
  input  logic [BCD_W-1:0] B,
  input  logic [BCD_W-1:0] C,
  input  logic [BCD_W-1:0] D,
  input  logic             start,
  output logic [BIN_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int SR_W = DIGITS * BCD_W;

  state_e                 state_q;
  logic [SR_W-1:0]        digits_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [BIN_W-1:0]       acc_q;
  logic [BIN_W-1:0]       acc_d;
  logic [BIN_W-1:0]       value_q;
  logic                   invalid_q;
  logic                   invalid_d;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;
  logic                   last_digit;

  bcd_times10_add u_times10_add (
    .acc    (acc_q),
    .digit  (digits_q[SR_W-1 -: BCD_W]),
    .result (acc_d)
  );

  assign invalid_d  = !(is_bcd(A) && is_bcd(B) && is_bcd(C) && is_bcd(D));
  assign last_digit = (cnt_q == CNT_W'(DIGITS-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      digits_q  <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      value_q   <= '0;
      invalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            digits_q  <= {A, B, C, D};
            acc_q     <= '0;
            cnt_q     <= '0;
            invalid_q <= invalid_d;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= CONV;
          end
        end
        CONV: begin
          acc_q    <= acc_d;
          digits_q <= {digits_q[SR_W-BCD_W-1:0], {BCD_W{1'b0}}};
          cnt_q    <= cnt_q + 1'b1;
          if (last_digit) begin
            // A bad digit makes the truncated sum meaningless, so report zero.
            value_q <= invalid_q ? '0 : acc_d;
            err_q   <= invalid_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign value = value_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd2bin4digit.sv
// tb/tb_bcd2bin4digit.sv - self-checking bench for bcd2bin4digit against an arithmetic model
module tb_bcd2bin4digit;

  logic        clk;
  logic        rst;
  logic [3:0]  A, B, C, D;
  logic        start;
  logic [13:0] value;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  bcd2bin4digit dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_err(input int a, input int b, input int c, input int d);
    return (a > 9) || (b > 9) || (c > 9) || (d > 9);
  endfunction

  function automatic int model_val(input int a, input int b, input int c, input int d);
    if (model_err(a, b, c, d)) return 0;
    return a * 1000 + b * 100 + c * 10 + d;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic conv(input int a, input int b, input int c, input int d, input bit noise,
                      input int prev_val, input bit prev_err);
    int ev;
    bit ee;
    ev = model_val(a, b, c, d);
    ee = model_err(a, b, c, d);
    @(negedge clk);
    A = 4'(a); B = 4'(b); C = 4'(c); D = 4'(d);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    check("done_after_accept", int'(done), 0);
    check("err_cleared_at_accept", int'(err), 0);
    check("value_held_in_conv", int'(value), prev_val);
    for (int k = 1; k <= 3; k++) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        A = 4'($urandom); B = 4'($urandom); C = 4'($urandom); D = 4'($urandom);
      end
      @(negedge clk);
      check("busy_mid_conv", int'(busy), 1);
      check("done_mid_conv", int'(done), 0);
    end
    start = 1'b0;
    @(negedge clk);
    check("done_at_latency", int'(done), 1);
    check("busy_fall_with_done", int'(busy), 0);
    check("value", int'(value), ev);
    check("err", int'(err), int'(ee));
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("busy_stays_low", int'(busy), 0);
    if (prev_err) begin end
  endtask

  int last_val;
  bit last_err;
  int a, b, c, d;
  int done_cnt;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    A = 4'd0; B = 4'd0; C = 4'd0; D = 4'd0;
    repeat (2) @(negedge clk);
    check("reset_value", int'(value), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err), 0);
    rst = 1'b0;

    conv(1, 2, 3, 4, 1'b0, 0, 1'b0);
    conv(9, 9, 9, 9, 1'b0, 1234, 1'b0);
    conv(0, 0, 0, 0, 1'b0, 9999, 1'b0);
    conv(1, 10, 3, 4, 1'b0, 0, 1'b0);
    conv(0, 0, 4, 2, 1'b0, 0, 1'b1);
    conv(5, 6, 7, 8, 1'b1, 42, 1'b0);
    last_val = 5678;

    // Continuous start: a conversion every 5 clocks.
    @(negedge clk);
    A = 4'd0; B = 4'd1; C = 4'd0; D = 4'd0;
    start = 1'b1;
    done_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        check("b2b_value", int'(value), 100);
        check("b2b_period", i % 5, 0);
      end
    end
    start = 1'b0;
    check("b2b_done_count", done_cnt, 4);
    @(negedge clk);
    last_val = 100;

    // Asynchronous reset during the second CONV cycle.
    A = 4'd7; B = 4'd7; C = 4'd7; D = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_reset_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_value", int'(value), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_err", int'(err), 0);
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("no_done_after_abort", done_cnt, 0);
    check("idle_after_abort", int'(busy), 0);

    last_val = 0;
    last_err = 1'b0;
    conv(2, 0, 2, 5, 1'b0, last_val, last_err);
    last_val = 2025;

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, 15); b = $urandom_range(0, 15);
        c = $urandom_range(0, 15); d = $urandom_range(0, 15);
      end else begin
        a = $urandom_range(0, 9); b = $urandom_range(0, 9);
        c = $urandom_range(0, 9); d = $urandom_range(0, 9);
      end
      conv(a, b, c, d, n[0], last_val, last_err);
      last_val = model_val(a, b, c, d);
      last_err = model_err(a, b, c, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
